// File: rtl/sram_port_responder_pkg.sv
// Shared types for the SRAM port responder: client ids, op codes and read tag record.
package sram_port_responder_pkg;

  typedef enum logic {
    CLI_MAIN = 1'b0,
    CLI_SHI  = 1'b1
  } client_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned RD_TAG_WIDTH = 1 + 1;

  typedef struct packed {
    logic    valid;
    client_e client;
  } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, client_id} alongside in-flight SRAM reads.
module sram_rd_tag_pipe
  import sram_port_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic    clk,
  input  logic    clear,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (clear) begin
      stages <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/sram_port_responder.sv
// Arbitrates main and shifter read/write requests onto one single-ported synchronous SRAM
// and routes read returns back to the issuing client.
module sram_port_responder
  import sram_port_responder_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter int unsigned SRAM_DATA_WIDTH = 72,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_STARVE      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_ack,
  input  logic                       rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_ack,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       rd_vld,
  input  logic                       wr_shi_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_shi_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] wr_shi_data,
  output logic                       wr_shi_ack,
  input  logic                       rd_shi_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_shi_addr,
  output logic                       rd_shi_ack,
  output logic [SRAM_DATA_WIDTH-1:0] rd_shi_data,
  output logic                       rd_shi_vld,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we,
  output logic                       sram_re,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0]        starve_cnt;
  logic                       main_any;
  logic                       shi_any;
  logic                       shi_wins;
  logic                       grant_valid;
  op_e                        grant_op;
  client_e                    grant_client;
  logic [SRAM_ADDR_WIDTH-1:0] grant_addr;
  logic [SRAM_DATA_WIDTH-1:0] grant_data;
  rd_tag_t                    tag_in;
  rd_tag_t                    tag_out;

  assign main_any = wr_req | rd_req;
  assign shi_any  = wr_shi_req | rd_shi_req;
  // Shifter normally wins; main takes the slot once it has waited MAX_STARVE shifter grants.
  assign shi_wins = shi_any && !(main_any && (starve_cnt == STARVE_LIMIT));

  always_comb begin
    wr_ack     = 1'b0;
    rd_ack     = 1'b0;
    wr_shi_ack = 1'b0;
    rd_shi_ack = 1'b0;
    if (!reset) begin
      if (shi_wins) begin
        if (wr_shi_req) wr_shi_ack = 1'b1;
        else            rd_shi_ack = 1'b1;
      end else if (main_any) begin
        if (wr_req) wr_ack = 1'b1;
        else        rd_ack = 1'b1;
      end
    end
  end

  always_comb begin
    grant_valid  = wr_ack | rd_ack | wr_shi_ack | rd_shi_ack;
    grant_op     = (wr_ack | wr_shi_ack) ? OP_WR : OP_RD;
    grant_client = (wr_shi_ack | rd_shi_ack) ? CLI_SHI : CLI_MAIN;
    grant_data   = wr_shi_ack ? wr_shi_data : wr_data;
    grant_addr   = '0;
    if (wr_shi_ack)      grant_addr = wr_shi_addr;
    else if (rd_shi_ack) grant_addr = rd_shi_addr;
    else if (wr_ack)     grant_addr = wr_addr;
    else if (rd_ack)     grant_addr = rd_addr;
    tag_in.valid  = grant_valid && (grant_op == OP_RD);
    tag_in.client = grant_client;
  end

  always_ff @(posedge clk) begin
    if (reset || !main_any || wr_ack || rd_ack) begin
      starve_cnt <= '0;
    end else if ((wr_shi_ack || rd_shi_ack) && (starve_cnt < STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_we      <= 1'b0;
      sram_re      <= 1'b0;
      sram_addr    <= '0;
      sram_wr_data <= '0;
    end else begin
      sram_we <= grant_valid && (grant_op == OP_WR);
      sram_re <= grant_valid && (grant_op == OP_RD);
      if (grant_valid) sram_addr <= grant_addr;
      if (grant_valid && (grant_op == OP_WR)) sram_wr_data <= grant_data;
    end
  end

  sram_rd_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .clear  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data     <= '0;
      rd_shi_data <= '0;
      rd_vld      <= 1'b0;
      rd_shi_vld  <= 1'b0;
    end else begin
      rd_data     <= sram_rd_data;
      rd_shi_data <= sram_rd_data;
      rd_vld      <= tag_out.valid && (tag_out.client == CLI_MAIN);
      rd_shi_vld  <= tag_out.valid && (tag_out.client == CLI_SHI);
    end
  end

endmodule

// File: tb/tb_sram_port_responder.sv
// Directed and randomized checks of sram_port_responder against a transaction-level model.
module tb_sram_port_responder;

  localparam int AW = 19;
  localparam int DW = 72;
  localparam int RL = 2;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0, wr_shi_req = 1'b0, rd_shi_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0, wr_shi_addr = '0, rd_shi_addr = '0;
  logic [DW-1:0] wr_data = '0, wr_shi_data = '0;
  logic          wr_ack, rd_ack, wr_shi_ack, rd_shi_ack;
  logic [DW-1:0] rd_data, rd_shi_data;
  logic          rd_vld, rd_shi_vld;
  logic [AW-1:0] sram_addr;
  logic          sram_we, sram_re;
  logic [DW-1:0] sram_wr_data, sram_rd_data;

  always #5 clk = ~clk;

  sram_port_responder #(
    .SRAM_ADDR_WIDTH(AW),
    .SRAM_DATA_WIDTH(DW),
    .READ_LATENCY   (RL),
    .MAX_STARVE     (MS)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_vld(rd_vld),
    .wr_shi_req(wr_shi_req), .wr_shi_addr(wr_shi_addr), .wr_shi_data(wr_shi_data),
    .wr_shi_ack(wr_shi_ack),
    .rd_shi_req(rd_shi_req), .rd_shi_addr(rd_shi_addr), .rd_shi_ack(rd_shi_ack),
    .rd_shi_data(rd_shi_data), .rd_shi_vld(rd_shi_vld),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
  );

  // Power-on SRAM contents: a known pattern, with 0xAB planted at word 0x10.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == AW'(16)) return DW'(8'hAB);
    return {8'hC3, 45'd0, a};
  endfunction

  // Physical SRAM model; the bench only uses addresses below 256.
  logic [DW-1:0] mem [256];
  bit            wrote [256];
  logic [DW-1:0] rdp [RL];

  always @(posedge clk) begin
    if (sram_we) begin
      mem[sram_addr[7:0]]   <= sram_wr_data;
      wrote[sram_addr[7:0]] <= 1'b1;
    end
    rdp[0] <= !sram_re ? {DW{1'bx}} :
              (wrote[sram_addr[7:0]] ? mem[sram_addr[7:0]] : init_word(sram_addr));
    for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
  end
  assign sram_rd_data = rdp[RL-1];

  // Reference model state.
  typedef struct {
    int            due;
    bit            cli;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       expq[$];
  logic [DW-1:0] smem [int];
  int            cyc = 0;
  int            mstarve = 0;
  bit            exp_we = 0, exp_re = 0, rst_prev = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  bit            act_wr, act_rd, act_wr_shi, act_rd_shi;
  int            n_vm = 0, n_vs = 0, shi_run = 0, max_run = 0;
  logic [DW-1:0] last_rd_data = '0;
  int            checks = 0, errors = 0;

  function automatic logic [DW-1:0] sread(input logic [AW-1:0] a);
    if (smem.exists(int'(a))) return smem[int'(a)];
    return init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic eval_cycle();
    int            g;
    bit            main_any, shi_any, exp_vm, exp_vs;
    logic [DW-1:0] exp_d;
    rd_exp_t       r;
    act_wr = wr_ack; act_rd = rd_ack; act_wr_shi = wr_shi_ack; act_rd_shi = rd_shi_ack;
    if (rd_vld === 1'b1) begin n_vm++; last_rd_data = rd_data; end
    if (rd_shi_vld === 1'b1) begin n_vs++; shi_run++; end else shi_run = 0;
    if (shi_run > max_run) max_run = shi_run;
    if (reset) begin
      chk("ack_in_reset", DW'({wr_ack, rd_ack, wr_shi_ack, rd_shi_ack}), '0);
      if (rst_prev) begin
        chk("cmd_in_reset", DW'({sram_we, sram_re}), '0);
        chk("addr_in_reset", DW'(sram_addr), '0);
        chk("wdata_in_reset", sram_wr_data, '0);
        chk("vld_in_reset", DW'({rd_vld, rd_shi_vld}), '0);
        chk("rd_data_in_reset", rd_data, '0);
        chk("rd_shi_data_in_reset", rd_shi_data, '0);
      end
      expq.delete();
      mstarve = 0; exp_we = 0; exp_re = 0; rst_prev = 1;
      return;
    end
    rst_prev = 0;
    main_any = wr_req || rd_req;
    shi_any  = wr_shi_req || rd_shi_req;
    g = 0;
    if (shi_any && !(main_any && mstarve == MS)) g = wr_shi_req ? 3 : 4;
    else if (main_any) g = wr_req ? 1 : 2;
    chk1("wr_ack", wr_ack, g == 1);
    chk1("rd_ack", rd_ack, g == 2);
    chk1("wr_shi_ack", wr_shi_ack, g == 3);
    chk1("rd_shi_ack", rd_shi_ack, g == 4);
    chk1("sram_we", sram_we, exp_we);
    chk1("sram_re", sram_re, exp_re);
    if (exp_we || exp_re) chk("sram_addr", DW'(sram_addr), DW'(exp_addr));
    if (exp_we) chk("sram_wr_data", sram_wr_data, exp_wdata);
    exp_vm = 0; exp_vs = 0; exp_d = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      r = expq.pop_front();
      exp_vm = !r.cli; exp_vs = r.cli; exp_d = r.data;
    end
    chk1("rd_vld", rd_vld, exp_vm);
    chk1("rd_shi_vld", rd_shi_vld, exp_vs);
    if (exp_vm) chk("rd_data", rd_data, exp_d);
    if (exp_vs) chk("rd_shi_data", rd_shi_data, exp_d);
    exp_we = (g == 1) || (g == 3);
    exp_re = (g == 2) || (g == 4);
    case (g)
      1: begin exp_addr = wr_addr; exp_wdata = wr_data; smem[int'(wr_addr)] = wr_data; end
      3: begin exp_addr = wr_shi_addr; exp_wdata = wr_shi_data; smem[int'(wr_shi_addr)] = wr_shi_data; end
      2: begin exp_addr = rd_addr; expq.push_back('{cyc + RL + 2, 1'b0, sread(rd_addr)}); end
      4: begin exp_addr = rd_shi_addr; expq.push_back('{cyc + RL + 2, 1'b1, sread(rd_shi_addr)}); end
      default: ;
    endcase
    if (!main_any || g == 1 || g == 2) mstarve = 0;
    else if (g >= 3) mstarve++;
  endtask

  task automatic tick();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    int vm0, vs0, issued;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Single main read of the planted word
    rd_req = 1'b1; rd_addr = AW'(16);
    tick();
    chk1("t1_rd_ack", act_rd, 1'b1);
    rd_req = 1'b0;
    vm0 = n_vm; vs0 = n_vs;
    repeat (5) tick();
    chk("t1_vld_count", DW'(n_vm - vm0), DW'(1));
    chk("t1_rd_data", last_rd_data, DW'(8'hAB));
    chk("t1_shi_vld_count", DW'(n_vs - vs0), '0);

    // Write then read, same address, main port
    wr_req = 1'b1; wr_addr = AW'(5); wr_data = DW'(12'h123);
    rd_req = 1'b1; rd_addr = AW'(5);
    tick();
    chk1("t2_wr_first", act_wr, 1'b1);
    wr_req = 1'b0;
    tick();
    chk1("t2_rd_second", act_rd, 1'b1);
    rd_req = 1'b0;
    repeat (5) tick();
    chk("t2_rd_data", last_rd_data, DW'(12'h123));

    // Starvation limit: four shifter grants, then one main grant
    rd_shi_req = 1'b1; rd_shi_addr = AW'(32);
    rd_req = 1'b1; rd_addr = AW'(64);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t3_pattern", DW'({act_rd_shi, act_rd}), (k % 5 == 4) ? DW'(2'b01) : DW'(2'b10));
      if (act_rd) rd_addr = rd_addr + 1'b1;
      if (act_rd_shi) rd_shi_addr = rd_shi_addr + 1'b1;
    end
    rd_req = 1'b0; rd_shi_req = 1'b0;
    repeat (6) tick();

    // Back-to-back shifter reads of addresses 0..7
    max_run = 0; issued = 0;
    rd_shi_req = 1'b1; rd_shi_addr = '0;
    for (int k = 0; k < 20 && issued < 8; k++) begin
      tick();
      if (act_rd_shi) begin
        issued++;
        rd_shi_addr = rd_shi_addr + 1'b1;
        if (issued == 8) rd_shi_req = 1'b0;
      end
    end
    chk("t4_issued", DW'(issued), DW'(8));
    rd_shi_req = 1'b0;
    repeat (8) tick();
    chk("t4_vld_run", DW'(max_run), DW'(8));

    // Reset two cycles after a read grant drops the read
    rd_req = 1'b1; rd_addr = AW'(16);
    tick();
    chk1("t5_rd_ack", act_rd, 1'b1);
    rd_req = 1'b0;
    vm0 = n_vm; vs0 = n_vs;
    tick();
    reset = 1'b1; rd_req = 1'b1; wr_shi_req = 1'b1;
    repeat (3) tick();
    reset = 1'b0; rd_req = 1'b0; wr_shi_req = 1'b0;
    repeat (10) tick();
    chk("t5_no_vld", DW'((n_vm - vm0) + (n_vs - vs0)), '0);

    // Idle
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t6_starve_cnt", DW'(dut.starve_cnt), '0);
    end

    // Randomized traffic on a small address range to provoke hazards
    for (int n = 0; n < 800; n++) begin
      tick();
      if (act_wr || !wr_req) begin
        wr_req = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom_range(0, 15)); wr_data = rnd_data();
      end
      if (act_rd || !rd_req) begin
        rd_req = ($urandom_range(0, 1) == 0);
        rd_addr = AW'($urandom_range(0, 15));
      end
      if (act_wr_shi || !wr_shi_req) begin
        wr_shi_req = ($urandom_range(0, 2) == 0);
        wr_shi_addr = AW'($urandom_range(0, 15)); wr_shi_data = rnd_data();
      end
      if (act_rd_shi || !rd_shi_req) begin
        rd_shi_req = ($urandom_range(0, 1) == 0);
        rd_shi_addr = AW'($urandom_range(0, 15));
      end
    end
    wr_req = 1'b0; rd_req = 1'b0; wr_shi_req = 1'b0; rd_shi_req = 1'b0;
    repeat (8) tick();
    chk("drain_pending", DW'(expq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
